// File: rtl/audio_track_scheduler.sv
// rtl/audio_track_scheduler.sv - shares one SD block-read port between two double-buffered audio tracks
//
// Ports:
//   MasterCLK, Reset            : clock and synchronous active-high reset
//   TnBeginAddr/TnEndAddr       : inclusive block range of track n
//   TnPlay/TnLoop               : play level (rising edge starts) and loop-at-end level
//   TnRefill                    : one-cycle pulse, consumer drained a bank of track n
//   SD_Ready/SD_Done/SD_Error   : SD block-read controller status
//   SD_ReadStart/SD_Address     : read command and block address
//   DestTrack/DestBank/Busy     : destination tag of the outstanding transfer
//   TnActive/TnFinished         : track playing level, end/abort pulse
module audio_track_scheduler #(
    parameter int ADDR_WIDTH     = 24,
    parameter int MAX_RETRIES    = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  MasterCLK,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] T1BeginAddr,
    input  logic [ADDR_WIDTH-1:0] T1EndAddr,
    input  logic                  T1Play,
    input  logic                  T1Loop,
    input  logic [ADDR_WIDTH-1:0] T2BeginAddr,
    input  logic [ADDR_WIDTH-1:0] T2EndAddr,
    input  logic                  T2Play,
    input  logic                  T2Loop,
    input  logic                  T1Refill,
    input  logic                  T2Refill,
    input  logic                  SD_Ready,
    input  logic                  SD_Done,
    input  logic                  SD_Error,
    output logic                  SD_ReadStart,
    output logic [ADDR_WIDTH-1:0] SD_Address,
    output logic                  DestTrack,
    output logic                  DestBank,
    output logic                  Busy,
    output logic                  T1Active,
    output logic                  T2Active,
    output logic                  T1Finished,
    output logic                  T2Finished
);

    localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_RETRY} state_t;
    state_t state, next_state;

    logic [1:0] play, loop, refill, play_q, rise;
    logic [1:0] active, last, bank, gen, fin;
    logic [1:0] elig, done_hit, retry_hit, refill_ok;
    logic [ADDR_WIDTH-1:0] begin_in [2];
    logic [ADDR_WIDTH-1:0] end_in [2];
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [ADDR_WIDTH-1:0] end_q [2];
    logic [1:0] pending [2];
    logic [1:0] pend_net [2];
    logic [2:0] pend_sum [2];
    logic [RW-1:0] retry [2];
    logic rr, sel, cur_gen, dest_track, dest_bank;
    logic [TW-1:0] to_cnt;
    logic [ADDR_WIDTH-1:0] sd_addr;

    assign play        = {T2Play, T1Play};
    assign loop        = {T2Loop, T1Loop};
    assign refill      = {T2Refill, T1Refill};
    assign begin_in[0] = T1BeginAddr;
    assign begin_in[1] = T2BeginAddr;
    assign end_in[0]   = T1EndAddr;
    assign end_in[1]   = T2EndAddr;
    assign rise        = play & ~play_q;

    assign SD_ReadStart = (state == S_ISSUE);
    assign Busy         = (state == S_ISSUE) || (state == S_WAIT);
    assign SD_Address   = sd_addr;
    assign DestTrack    = dest_track;
    assign DestBank     = dest_bank;
    assign T1Active     = active[0];
    assign T2Active     = active[1];
    assign T1Finished   = fin[0];
    assign T2Finished   = fin[1];

    // A completed transfer only counts if its track is still active and has not
    // been restarted since the read was latched (generation tag match).
    always_comb begin
        for (int t = 0; t < 2; t++) begin
            elig[t]      = active[t] && (pending[t] != 2'd0);
            refill_ok[t] = refill[t] && active[t] && !last[t];
            done_hit[t]  = (state == S_DONE) && (dest_track == 1'(t)) &&
                           (gen[t] == cur_gen) && active[t];
            retry_hit[t] = (state == S_RETRY) && (dest_track == 1'(t)) &&
                           (gen[t] == cur_gen) && active[t];
            pend_sum[t]  = {1'b0, pending[t]} + {2'b00, refill_ok[t]} - {2'b00, done_hit[t]};
            pend_net[t]  = (pend_sum[t] > 3'd2) ? 2'd2 : pend_sum[t][1:0];
        end
        sel = (elig[0] && elig[1]) ? rr : ~elig[0];
    end

    always_ff @(posedge MasterCLK) begin
        if (Reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (SD_Ready && (elig != 2'b00)) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT: begin
                if (SD_Done)                next_state = SD_Error ? S_RETRY : S_DONE;
                else if (to_cnt == TO_LAST) next_state = S_RETRY;
            end
            S_DONE:  next_state = S_IDLE;
            S_RETRY: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge MasterCLK) begin
        if (Reset) begin
            play_q     <= play;
            active     <= '0;
            last       <= '0;
            bank       <= '0;
            gen        <= '0;
            fin        <= '0;
            rr         <= 1'b0;
            cur_gen    <= 1'b0;
            to_cnt     <= '0;
            sd_addr    <= '0;
            dest_track <= 1'b0;
            dest_bank  <= 1'b0;
            for (int t = 0; t < 2; t++) begin
                addr[t]    <= '0;
                end_q[t]   <= '0;
                pending[t] <= '0;
                retry[t]   <= '0;
            end
        end else begin
            play_q <= play;
            fin    <= '0;
            case (state)
                S_IDLE: begin
                    if (next_state == S_ISSUE) begin
                        sd_addr    <= addr[sel];
                        dest_track <= sel;
                        dest_bank  <= bank[sel];
                        cur_gen    <= gen[sel];
                    end
                end
                S_ISSUE: to_cnt <= '0;
                S_WAIT:  to_cnt <= to_cnt + TW'(1);
                S_DONE, S_RETRY: begin
                    sd_addr    <= '0;
                    dest_track <= 1'b0;
                    dest_bank  <= 1'b0;
                    if (state == S_DONE) rr <= ~dest_track;
                end
                default: ;
            endcase

            for (int t = 0; t < 2; t++) begin
                if (!play[t]) begin
                    active[t]  <= 1'b0;
                    pending[t] <= 2'd0;
                end else if (rise[t]) begin
                    if ((begin_in[t] <= end_in[t])) begin
                        active[t]  <= 1'b1;
                        addr[t]    <= begin_in[t];
                        end_q[t]   <= end_in[t];
                        bank[t]    <= 1'b0;
                        pending[t] <= 2'd2;
                        last[t]    <= 1'b0;
                        retry[t]   <= '0;
                        gen[t]     <= ~gen[t];
                    end else begin
                        fin[t] <= 1'b1;
                    end
                end else begin
                    pending[t] <= pend_net[t];
                    if (done_hit[t]) begin
                        bank[t]  <= ~bank[t];
                        retry[t] <= '0;
                        if (addr[t] == end_q[t]) begin
                            if (loop[t]) begin
                                addr[t]  <= begin_in[t];
                                end_q[t] <= end_in[t];
                            end else begin
                                last[t]    <= 1'b1;
                                active[t]  <= 1'b0;
                                pending[t] <= 2'd0;
                                fin[t]     <= 1'b1;
                            end
                        end else begin
                            addr[t] <= addr[t] + ADDR_WIDTH'(1);
                        end
                    end
                    if (retry_hit[t]) begin
                        if (retry[t] < RETRY_LAST) begin
                            retry[t] <= retry[t] + RW'(1);
                        end else begin
                            active[t]  <= 1'b0;
                            pending[t] <= 2'd0;
                            fin[t]     <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
